seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. One BCD-to-segment decode path is shared across NUM_DIGITS digits. The controller cycles a one-hot digit enable and inserts an anti-ghosting blank gap between digits. New display values are loaded through a ready/load handshake and applied only at frame boundaries, so a frame never shows a mix of old and new values. It sits between the numeric datapath (counters, BCD converters) and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be >= 2.
PRESCALE, 50000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 500, cycles at the start of each slot with all outputs off; must satisfy 0 <= BLANK_CYCLES < PRESCALE.

Ports:
iClk  input  1  system clock; all state updates on rising edge.
iRst_n  input  1  asynchronous active-low reset.
iData  input  4*NUM_DIGITS  packed BCD value; nibble k ([4k+3:4k]) drives digit k; digit 0 is least significant.
iLoad  input  1  load strobe; sampled only while oReady=1.
oReady  output  1  high when no load is pending.
oFrame  output  1  one-cycle pulse after each frame boundary.
oSeg  output  7  segments abcdefg, active-high, bit 6 = a.
oDigit  output  NUM_DIGITS  one-hot digit enable, active-high; bit k selects digit k.

Behaviour:
- Reset (iRst_n=0, asynchronous):
  - Slot counter cnt=0, digit index idx=0.
  - Display register disp=0, pending register pend=0, pending flag=0.
  - Outputs: oReady=1, oFrame=0, oSeg=0, oDigit=0.
- Slot counter: cnt increments 0..PRESCALE-1 and wraps to 0. On wrap, idx increments 0..NUM_DIGITS-1 and wraps to 0. A frame is NUM_DIGITS*PRESCALE cycles.
- Phase per slot:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE otherwise.
- Output computation (registered; oSeg and oDigit reflect the cnt/idx values held before the edge, i.e. 1-cycle latency):
  - BLANK: oDigit=0, oSeg=0.
  - DRIVE: oDigit=1<<idx, oSeg=decode(disp nibble idx).
- Decode table (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Nibbles 10-15 give 0000000; the decoder holds no previous value, because it is shared across digits.
- Load handshake:
  - iLoad=1 while oReady=1: pend<=iData, pending flag<=1, oReady<=0 on the next edge.
  - iLoad=1 while oReady=0: ignored; pend is unchanged.
- Frame boundary (cnt=PRESCALE-1 and idx=NUM_DIGITS-1):
  - If the pending flag is set: disp<=pend, flag<=0, oReady<=1.
  - oFrame<=1 for exactly one cycle whether or not a swap occurred.
  - New data is first visible in slot 0 of the next frame.
  - iLoad accepted in the boundary cycle itself (oReady was 1): the load is captured, and the swap happens at the following boundary.
- Reset mid-operation: all outputs go to 0 immediately. After release, scanning restarts at idx=0, cnt=0 (a BLANK phase first), showing disp=0. Any pending load is discarded.
- iData is sampled only on an accepted iLoad; changes at other times have no effect.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: in DRIVE, digit k>0 outputs oSeg=0000000 when nibble k and every higher nibble of disp are 0. oDigit is still asserted for that slot. Digit 0 always decodes normally.
- Undefined: every digit decodes normally, so zeros show as 1111110.
- Timing and handshake are identical in both builds.

Test Plan:
Bench parameters: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 (frame = 32 cycles; 6 DRIVE cycles per slot).
1. Reset check: assert iRst_n=0 mid-DRIVE -> oSeg=0, oDigit=0, oReady=1, oFrame=0 without waiting for a clock edge. Release -> first 2 slot cycles have oDigit=0000, then oDigit=0001 with oSeg=1111110 for 6 cycles.
2. Normal load: iData=16'h1234, iLoad pulsed 1 cycle -> oReady=0 until the frame boundary; oFrame pulses 1 cycle and oReady returns to 1. Next frame: digit0 oSeg=0110011 (4), digit1 1111001 (3), digit2 1101101 (2), digit3 0110000 (1), each with its one-hot oDigit for 6 cycles, separated by 2-cycle all-zero gaps.
3. Invalid nibble: load 16'h00A7 -> digit0=1110000 (7); digit1 oDigit=0010 with oSeg=0000000.
4. Blocked load: load 16'h1111, then iLoad with 16'h9999 while oReady=0 -> second load ignored; display shows 0110000 on all digits; oFrame still pulses every 32 cycles.
5. Boundary coincidence: iLoad with 16'h0008 in the boundary cycle while oReady=1 -> old value shown for one more frame; new value appears after the next oFrame.
6. Leading-zero blanking: load 16'h0005 -> macro defined: digits1-3 oSeg=0000000, digit0 1011011. Macro undefined: digits1-3 1111110, digit0 1011011.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, one-hot digit scan with blank gap,
// double-buffered display value swapped only at frame boundaries. Optional macro: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic [4*NUM_DIGITS-1:0] iData,
    input  logic                    iLoad,
    output logic                    oReady,
    output logic                    oFrame,
    output logic [6:0]              oSeg,
    output logic [NUM_DIGITS-1:0]   oDigit
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    localparam logic [0:0] PH_BLANK = 1'b0;
    localparam logic [0:0] PH_DRIVE = 1'b1;

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_disp;
    logic [DW-1:0]         r_pend;
    logic                  r_pflag;
    logic                  r_frame;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_digit;

    logic                  w_cnt_wrap;
    logic                  w_boundary;
    logic [0:0]            w_phase;
    logic [3:0]            w_nib;
    logic [6:0]            w_dec;
    logic [6:0]            w_seg_drv;

    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_boundary = w_cnt_wrap && (r_idx == IDX_LAST);
    assign w_phase    = (r_cnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
    assign w_nib      = r_disp[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_dec = 7'b0000000;
        case (w_nib)
            4'd0: w_dec = 7'b1111110;
            4'd1: w_dec = 7'b0110000;
            4'd2: w_dec = 7'b1101101;
            4'd3: w_dec = 7'b1111001;
            4'd4: w_dec = 7'b0110011;
            4'd5: w_dec = 7'b1011011;
            4'd6: w_dec = 7'b1011111;
            4'd7: w_dec = 7'b1110000;
            4'd8: w_dec = 7'b1111111;
            4'd9: w_dec = 7'b1111011;
            default: w_dec = 7'b0000000;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant nibble are zero; digit 0 never blanks.
    logic w_lead_zero;
    assign w_lead_zero = (r_idx != '0) && ((r_disp >> {r_idx, 2'b00}) == '0);
    assign w_seg_drv   = w_lead_zero ? 7'b0000000 : w_dec;
`else
    assign w_seg_drv   = w_dec;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_disp  <= '0;
            r_pend  <= '0;
            r_pflag <= 1'b0;
            r_frame <= 1'b0;
            r_seg   <= 7'b0000000;
            r_digit <= '0;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            if (w_cnt_wrap)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

            // Swap has priority; a load arriving while pending is already ignored since oReady is low.
            if (w_boundary && r_pflag) begin
                r_disp  <= r_pend;
                r_pflag <= 1'b0;
            end else if (iLoad && !r_pflag) begin
                r_pend  <= iData;
                r_pflag <= 1'b1;
            end

            r_frame <= w_boundary;
            if (w_phase == PH_DRIVE) begin
                r_seg   <= w_seg_drv;
                r_digit <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
            end else begin
                r_seg   <= 7'b0000000;
                r_digit <= '0;
            end
        end
    end

    assign oReady = ~r_pflag;
    assign oFrame = r_frame;
    assign oSeg   = r_seg;
    assign oDigit = r_digit;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_seg7_scan_ctrl;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SX = 7'b0000000;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b0000000;
`else
    localparam logic [6:0] LZ = 7'b1111110;
`endif

    typedef struct {
        logic [15:0]     data;
        logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic [15:0] iData;
    logic        iLoad;
    logic        oReady;
    logic        oFrame;
    logic [6:0]  oSeg;
    logic [3:0]  oDigit;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iLoad(iLoad),
        .oReady(oReady), .oFrame(oFrame), .oSeg(oSeg), .oDigit(oDigit)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts right after a frame boundary edge (cnt=0, idx=0); samples 32 cycles on the falling edge.
    task automatic check_frame(input logic [3:0][6:0] segs, input string tag);
        for (int j = 0; j < 32; j++) begin
            int slot, c;
            logic [3:0] e_dig;
            logic [6:0] e_seg;
            @(negedge iClk);
            slot  = j / 8;
            c     = j % 8;
            e_dig = (c < 2) ? 4'b0000 : (4'b0001 << slot);
            e_seg = (c < 2) ? 7'b0000000 : segs[slot];
            check($sformatf("%s c%0d {digit,seg,frame}", tag, j),
                  {21'd0, oDigit, oSeg, oFrame}, {21'd0, e_dig, e_seg, (j == 31)});
        end
    endtask

    task automatic do_load(input logic [15:0] d);
        iData = d;
        iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        check($sformatf("ready low after load %h", d), {31'd0, oReady}, 32'd0);
    endtask

    task automatic wait_frame(input string tag);
        logic early;
        logic seen;
        early = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 70 && !seen; k++) begin
            @(negedge iClk);
            if (oFrame) seen = 1'b1;
            else if (oReady) early = 1'b1;
        end
        check({tag, " frame seen"}, {31'd0, seen}, 32'd1);
        check({tag, " ready held low"}, {31'd0, early}, 32'd0);
        check({tag, " ready after swap"}, {31'd0, oReady}, 32'd1);
    endtask

    vec_t vecs [5];
    logic [3:0][6:0] zero_segs;
    logic [3:0][6:0] ones_segs;

    initial begin
        vecs[0].data = 16'h1234; vecs[0].seg = {S1, S2, S3, S4};
        vecs[1].data = 16'h00A7; vecs[1].seg = {LZ, LZ, SX, S7};
        vecs[2].data = 16'h0005; vecs[2].seg = {LZ, LZ, LZ, S5};
        vecs[3].data = 16'h9876; vecs[3].seg = {S9, S8, S7, S6};
        vecs[4].data = 16'h1050; vecs[4].seg = {S1, S0, S5, S0};
        zero_segs = {LZ, LZ, LZ, S0};
        ones_segs = {S1, S1, S1, S1};

        iRst_n = 1'b0;
        iLoad  = 1'b0;
        iData  = 16'h0000;
        #1;
        check("reset seg",   {25'd0, oSeg},   32'd0);
        check("reset digit", {28'd0, oDigit}, 32'd0);
        check("reset ready", {31'd0, oReady}, 32'd1);
        check("reset frame", {31'd0, oFrame}, 32'd0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        check_frame(zero_segs, "post-reset");

        for (int i = 0; i < 5; i++) begin
            do_load(vecs[i].data);
            wait_frame($sformatf("vec%0d", i));
            check_frame(vecs[i].seg, $sformatf("vec%0d %h", i, vecs[i].data));
        end

        // Second load while one is pending must not overwrite the pending value.
        do_load(16'h1111);
        iData = 16'h9999;
        iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        check("blocked ready", {31'd0, oReady}, 32'd0);
        wait_frame("blocked");
        check_frame(ones_segs, "blocked f1");
        check("blocked no repend", {31'd0, oReady}, 32'd1);
        check_frame(ones_segs, "blocked f2");

        // Load accepted in the boundary cycle swaps one frame later.
        repeat (31) @(negedge iClk);
        check("bnd ready before", {31'd0, oReady}, 32'd1);
        iData = 16'h0008;
        iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        check("bnd frame pulse", {31'd0, oFrame}, 32'd1);
        check("bnd captured",    {31'd0, oReady}, 32'd0);
        check_frame(ones_segs, "bnd old");
        check("bnd swapped", {31'd0, oReady}, 32'd1);
        check_frame({LZ, LZ, LZ, S8}, "bnd new");

        // Asynchronous reset mid-DRIVE with a load pending.
        do_load(16'h9876);
        repeat (4) @(negedge iClk);
        check("mid pre digit", {28'd0, oDigit}, 32'd1);
        check("mid pre seg",   {25'd0, oSeg},   {25'd0, S8});
        #2 iRst_n = 1'b0;
        #1;
        check("mid rst seg",   {25'd0, oSeg},   32'd0);
        check("mid rst digit", {28'd0, oDigit}, 32'd0);
        check("mid rst ready", {31'd0, oReady}, 32'd1);
        check("mid rst frame", {31'd0, oFrame}, 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        check_frame(zero_segs, "mid rel f1");
        check_frame(zero_segs, "mid rel f2");
        check("mid rel ready", {31'd0, oReady}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
